mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single cache-line memory port between instruction fetch (IF) and the data/memory stage (D).
//  IF issues one-cycle ic_enable pulses with line-aligned iaddr and waits for ic_done.
//  D issues reads and masked line writes.
//  Sits between the fetch unit, the memory stage and the cache; grants one transaction at a time and returns data to its owner.
//  Handles fetch redirects (set_rip) by squashing stale IF traffic.
// PARAMETERS
//  ADDR_W        64   address width
//  LINE_W        512  line width in bits; LINE_B = LINE_W/8 = 64 bytes
//  STARVE_LIMIT  4    consecutive D grants with IF pending before IF is forced (>=1)
// PORTS
//  clk        in   1       sole clock, rising edge
//  reset_n    in   1       synchronous, active-low reset
//  if_flush   in   1       fetch redirect (set_rip)
//  if_req     in   1       IF request pulse
//  if_addr    in   ADDR_W  IF line address
//  if_data    out  LINE_W  IF read line
//  if_done    out  1       one-cycle IF completion
//  d_req      in   1       D request pulse
//  d_we       in   1       1 = write, 0 = read
//  d_addr     in   ADDR_W  D address
//  d_wdata    in   LINE_W  write line
//  d_wmask    in   LINE_B  byte enables
//  d_data     out  LINE_W  D read line
//  d_done     out  1       one-cycle D completion
//  mem_enable out  1       one-cycle request pulse to cache
//  mem_we     out  1       write
//  mem_addr   out  ADDR_W  line address, low log2(LINE_B) bits forced 0
//  mem_wdata  out  LINE_W  write data
//  mem_wmask  out  LINE_B  byte enables
//  mem_rdata  in   LINE_W  read data, valid with mem_done
//  mem_done   in   1       completion, one cycle
// BEHAVIOUR
//  Reset (reset_n=0 at an edge), all outputs 0:
//   - state=IDLE; pending bits, drop flag and starvation count cleared.
//   - Reset overrides everything, including mid-transaction; the cache shares reset_n, so no response is owed.
//  Request capture:
//   - Each requester has a slot: pending bit plus latched address/we/wdata/wmask.
//   - Slot is set at the edge where its req=1.
//   - req while its own slot is pending or in flight is a protocol violation; the bench asserts on it.
//  States: IDLE, BUSY_IF, BUSY_D.
//  IDLE:
//   - Candidates are pending slots OR same-edge incoming reqs, so there are zero idle cycles.
//   - Default priority: D over IF.
//   - If IF is a candidate and starve_cnt==STARVE_LIMIT, IF wins.
//   - On grant:
//     - mem_enable=1 for exactly the next cycle.
//     - mem_* are registered from the winning slot and held stable until mem_done.
//     - The slot is cleared; state goes to BUSY_x.
//   - Latency: req at edge N gives mem_enable=1 during N..N+1.
//  starve_cnt (width clog2(STARVE_LIMIT+1)):
//   - +1 on each D grant while IF is pending (saturates).
//   - Cleared on any IF grant, or when IF is not pending.
//  BUSY_x:
//   - mem_done at edge M: x_data<=mem_rdata, x_done=1 during M..M+1, state->IDLE.
//   - A next grant can issue at edge M+1.
//   - mem_done is ignored in IDLE.
//   - D writes also pulse d_done; d_data is then unchanged.
//  if_flush:
//   - Clears the IF pending slot.
//   - In BUSY_IF, sets drop; the response is consumed, if_done is suppressed, and drop clears on mem_done.
//   - if_flush and if_req at the same edge: the new req is kept (the flush kills only older IF traffic).
//   - Flush has no effect on D traffic.
//  Simultaneous if_req and d_req in IDLE: D is granted, IF stays pending and is granted immediately after d_done.
//  Address: mem_addr = addr & ~(LINE_B-1) for both requesters.
// STRUCTURE
//  Package mem_arb_pkg:
//   - arb_state_t {IDLE, BUSY_IF, BUSY_D}
//   - req_id_t {REQ_IF, REQ_D}
//   - LINE_B and offset-mask constants
//  Sub-module arb_req_slot (one per requester): pending bit, latched request fields, set/clear/flush inputs.
//  Top level: FSM, starvation counter, output registers.
// TESTING
//  1. reset_n=0 mid BUSY_D -> next cycle all outputs 0, state IDLE; a later mem_done produces no done pulse.
//  2. if_req, addr 0x1047, at edge 10; mem_done at edge 14:
//     -> mem_enable=1 only in cycle 10-11, mem_addr=0x1040;
//     -> if_done=1 in cycle 14-15, if_data=mem_rdata.
//  3. if_req and d_req (read, 0x2000) at the same edge:
//     -> D granted first;
//     -> IF mem_enable exactly one cycle after d_done.
//  4. if_flush while in BUSY_IF, then mem_done -> if_done stays 0, state IDLE.
//     Repeat with if_flush+if_req at the same edge -> the new IF address is issued and completes.
//  5. IF held pending while D re-requests on every d_done, STARVE_LIMIT=4:
//     -> exactly 4 D grants, then an IF grant, then starve_cnt=0.
//  6. D write, wmask=64'h00FF, wdata=pattern:
//     -> mem_we=1, mem_wmask=64'h00FF, mem_wdata=pattern held until mem_done;
//     -> d_done pulses once, d_data unchanged.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and line-geometry constants for the memory-port arbiter.
// Pure declarations: no latency and no flow control of its own.
package mem_arb_pkg;
  localparam int ADDR_W = 64;
  localparam int LINE_W = 512;
  localparam int LINE_B = LINE_W / 8;
  localparam logic [ADDR_W-1:0] OFS_MASK = ADDR_W'(LINE_B - 1);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D} arb_state_t;
  typedef enum logic {REQ_IF, REQ_D} req_id_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
    logic [LINE_B-1:0] wmask;
  } mem_req_t;

  function automatic logic [ADDR_W-1:0] line_addr(input logic [ADDR_W-1:0] a);
    return a & ~OFS_MASK;
  endfunction
endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data-stage and cache-port signals of the arbiter; slave = arbiter view.
// Wires only: latency and flow control belong to the modules on either side.
interface mem_port_arbiter_if;
  import mem_arb_pkg::*;

  logic              if_flush;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [LINE_W-1:0] if_data;
  logic              if_done;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_B-1:0] d_wmask;
  logic [LINE_W-1:0] d_data;
  logic              d_done;

  logic              mem_enable;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_B-1:0] mem_wmask;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_done;

  modport slave (
    input  if_flush, if_req, if_addr,
    output if_data, if_done,
    input  d_req, d_we, d_addr, d_wdata, d_wmask,
    output d_data, d_done,
    output mem_enable, mem_we, mem_addr, mem_wdata, mem_wmask,
    input  mem_rdata, mem_done
  );

  modport master (
    output if_flush, if_req, if_addr,
    input  if_data, if_done,
    output d_req, d_we, d_addr, d_wdata, d_wmask,
    input  d_data, d_done,
    input  mem_enable, mem_we, mem_addr, mem_wdata, mem_wmask,
    output mem_rdata, mem_done
  );
endinterface

// File: rtl/arb_req_slot.sv
// One-deep request holder: latches a request on i_set, drops it on grant or flush.
// Latency 1 cycle; no backpressure, the requester must not re-request while held.
module arb_req_slot
  import mem_arb_pkg::*;
(
  input  logic     clk,
  input  logic     reset_n,
  input  logic     i_set,
  input  logic     i_clr,
  input  logic     i_flush,
  input  mem_req_t i_req,
  output logic     o_pend,
  output mem_req_t o_req
);
  logic     r_pend;
  mem_req_t r_req;

  // A same-edge grant consumes the incoming request directly, so it never becomes pending.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pend <= 1'b0;
      r_req  <= '0;
    end else begin
      if (i_set) r_req <= i_req;
      if (i_set && !i_clr)       r_pend <= 1'b1;
      else if (i_clr || i_flush) r_pend <= 1'b0;
    end
  end

  assign o_pend = r_pend;
  assign o_req  = r_req;
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one cache-line port between fetch and data stage; req->mem_enable 1 cycle, mem_done->done 1 cycle.
// One transaction in flight; later requests wait in per-requester slots, D first unless fetch is starved.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset_n,
  mem_port_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  arb_state_t        r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_starve_cnt;
  logic              r_drop;
  logic              r_mem_enable, r_mem_we, r_if_done, r_d_done;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [LINE_W-1:0] r_mem_wdata, r_if_data, r_d_data;
  logic [LINE_B-1:0] r_mem_wmask;

  mem_req_t w_if_in, w_d_in, w_if_slot, w_d_slot, w_if_sel, w_d_sel, w_grant_req;
  logic     w_if_pend, w_d_pend, w_if_cand, w_d_cand;
  logic     w_grant_if, w_grant_d, w_if_resp, w_d_resp;
  req_id_t  w_win;

  always_comb begin
    w_if_in      = '0;
    w_if_in.addr = bus.if_addr;
    w_d_in       = '{we: bus.d_we, addr: bus.d_addr, wdata: bus.d_wdata, wmask: bus.d_wmask};
  end

  arb_req_slot u_if_slot (
    .clk(clk), .reset_n(reset_n), .i_set(bus.if_req), .i_clr(w_grant_if),
    .i_flush(bus.if_flush), .i_req(w_if_in), .o_pend(w_if_pend), .o_req(w_if_slot)
  );

  arb_req_slot u_d_slot (
    .clk(clk), .reset_n(reset_n), .i_set(bus.d_req), .i_clr(w_grant_d),
    .i_flush(1'b0), .i_req(w_d_in), .o_pend(w_d_pend), .o_req(w_d_slot)
  );

  // Incoming requests compete in the same cycle they arrive; a flush kills only the held fetch.
  assign w_if_cand = (w_if_pend && !bus.if_flush) || bus.if_req;
  assign w_d_cand  = w_d_pend || bus.d_req;
  assign w_if_sel  = bus.if_req ? w_if_in : w_if_slot;
  assign w_d_sel   = bus.d_req  ? w_d_in  : w_d_slot;

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_grant_if)     w_state_nxt = BUSY_IF;
               else if (w_grant_d) w_state_nxt = BUSY_D;
      BUSY_IF,
      BUSY_D:  if (bus.mem_done)   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_win       = (w_if_cand && (!w_d_cand || r_starve_cnt == CNT_MAX)) ? REQ_IF : REQ_D;
    w_grant_if  = (r_state == IDLE) && w_if_cand && (w_win == REQ_IF);
    w_grant_d   = (r_state == IDLE) && w_d_cand  && (w_win == REQ_D);
    w_grant_req = (w_win == REQ_IF) ? w_if_sel : w_d_sel;
    w_if_resp   = (r_state == BUSY_IF) && bus.mem_done && !r_drop && !bus.if_flush;
    w_d_resp    = (r_state == BUSY_D) && bus.mem_done;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_mem_enable <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_wmask  <= '0;
      r_if_done    <= 1'b0;
      r_if_data    <= '0;
      r_d_done     <= 1'b0;
      r_d_data     <= '0;
      r_drop       <= 1'b0;
      r_starve_cnt <= '0;
    end else begin
      r_mem_enable <= w_grant_if || w_grant_d;
      if (w_grant_if || w_grant_d) begin
        r_mem_we    <= w_grant_req.we;
        r_mem_addr  <= line_addr(w_grant_req.addr);
        r_mem_wdata <= w_grant_req.wdata;
        r_mem_wmask <= w_grant_req.wmask;
      end
      r_if_done <= w_if_resp;
      if (w_if_resp) r_if_data <= bus.mem_rdata;
      r_d_done <= w_d_resp;
      if (w_d_resp && !r_mem_we) r_d_data <= bus.mem_rdata;
      // A flushed fetch still owns the port until its response drains.
      if (r_state == BUSY_IF && bus.mem_done)      r_drop <= 1'b0;
      else if (r_state == BUSY_IF && bus.if_flush) r_drop <= 1'b1;
      if (w_grant_if)                  r_starve_cnt <= '0;
      else if (w_grant_d && w_if_cand) r_starve_cnt <= (r_starve_cnt == CNT_MAX) ? CNT_MAX
                                                       : r_starve_cnt + CNT_W'(1);
      else if (!w_if_cand)             r_starve_cnt <= '0;
    end
  end

  assign bus.mem_enable = r_mem_enable;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;
  assign bus.mem_wmask  = r_mem_wmask;
  assign bus.if_done    = r_if_done;
  assign bus.if_data    = r_if_data;
  assign bus.d_done     = r_d_done;
  assign bus.d_data     = r_d_data;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a transaction-level reference model.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int LIM = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit                m_live = 0, m_rst = 0;
  bit                m_pif = 0, m_pd = 0, m_drop = 0, m_cur_we = 0;
  int                m_owner = 0;  // 0 none, 1 fetch, 2 data
  int                m_starve = 0;
  logic [ADDR_W-1:0] m_aif = '0;
  mem_req_t          m_dreq = '0;
  int                m_log[$];
  logic              e_en = 0, e_we = 0, e_ifd = 0, e_dd = 0;
  logic [ADDR_W-1:0] e_addr = '0;
  logic [LINE_W-1:0] e_wdata = '0, e_ifdata = '0, e_ddata = '0;
  logic [LINE_B-1:0] e_wmask = '0;

  always @(posedge clk) begin : model
    bit ifq, dq;
    int prev;
    if (!reset_n) begin
      m_live = 1; m_rst = 1;
      m_pif = 0; m_pd = 0; m_drop = 0; m_owner = 0; m_starve = 0; m_cur_we = 0;
      e_en = 0; e_we = 0; e_ifd = 0; e_dd = 0;
      e_addr = '0; e_wdata = '0; e_wmask = '0; e_ifdata = '0; e_ddata = '0;
    end else begin
      m_rst = 0;
      if ((bus.if_req && !bus.if_flush && (m_pif || m_owner == 1)) || (bus.d_req && (m_pd || m_owner == 2))) begin
        total++; bad++;
        $display("FAIL protocol: request while own slot busy at %0t", $time);
      end
      prev = m_owner;
      e_en = 0; e_ifd = 0; e_dd = 0;
      if (prev != 0 && bus.mem_done) begin
        if (prev == 1) begin
          if (!m_drop && !bus.if_flush) begin e_ifd = 1; e_ifdata = bus.mem_rdata; end
        end else begin
          e_dd = 1;
          if (!m_cur_we) e_ddata = bus.mem_rdata;
        end
        m_owner = 0; m_drop = 0;
      end else if (prev == 1 && bus.if_flush) begin
        m_drop = 1;
      end
      ifq = (m_pif && !bus.if_flush) || bus.if_req;
      if (bus.if_req) m_aif = bus.if_addr;
      dq = m_pd || bus.d_req;
      if (bus.d_req) begin
        m_dreq.we = bus.d_we; m_dreq.addr = bus.d_addr;
        m_dreq.wdata = bus.d_wdata; m_dreq.wmask = bus.d_wmask;
      end
      if (prev == 0 && (ifq || dq)) begin
        e_en = 1;
        if (ifq && (!dq || m_starve == LIM)) begin
          e_we = 0; e_addr = m_aif - (m_aif % LINE_B);
          m_cur_we = 0; m_owner = 1; m_starve = 0; ifq = 0;
          m_log.push_back(1);
        end else begin
          e_we = m_dreq.we; e_addr = m_dreq.addr - (m_dreq.addr % LINE_B);
          e_wdata = m_dreq.wdata; e_wmask = m_dreq.wmask;
          m_cur_we = m_dreq.we; m_owner = 2; dq = 0;
          m_starve = ifq ? ((m_starve < LIM) ? m_starve + 1 : LIM) : 0;
          m_log.push_back(2);
        end
      end else if (!ifq) begin
        m_starve = 0;
      end
      m_pif = ifq; m_pd = dq;
    end
  end

  always @(negedge clk) begin : compare
    if (m_live) begin
      chk("mem_enable", bus.mem_enable, e_en);
      chk("if_done", bus.if_done, e_ifd);
      chk("d_done", bus.d_done, e_dd);
      chk("if_data", bus.if_data, e_ifdata);
      chk("d_data", bus.d_data, e_ddata);
      if (m_rst || m_owner != 0) begin
        chk("mem_addr", bus.mem_addr, e_addr);
        chk("mem_we", bus.mem_we, e_we);
        if (m_rst || e_we) begin
          chk("mem_wdata", bus.mem_wdata, e_wdata);
          chk("mem_wmask", bus.mem_wmask, e_wmask);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic serve(input int k, input logic [LINE_W-1:0] rd);
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (bus.mem_enable) seen = 1;
      else tick();
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL serve_timeout: mem_enable never rose, want 1");
    end
    repeat (k - 1) tick();
    bus.mem_rdata = rd;
    bus.mem_done = 1;
    tick();
    bus.mem_done = 0;
  endtask

  logic [LINE_W-1:0] pat, rd3a, rd3b, rd5, rdx;

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    pat  = {16{32'hDEAD_BEEF}};
    rd3a = {8{64'h0123_4567_89AB_CDEF}};
    rd3b = {16{32'h3B3B_0001}};
    rd5  = {16{32'h5555_AAAA}};
    rdx  = {16{32'h7777_1234}};
    bus.if_flush = 0; bus.if_req = 0; bus.if_addr = '0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_wmask = '0;
    bus.mem_rdata = '0; bus.mem_done = 0;
    repeat (2) tick();
    chk("reset_mem_enable", bus.mem_enable, 0);
    chk("reset_state", dut.r_state, IDLE);
    reset_n = 1;
    tick();

    // 1: reset in the middle of a data read
    bus.d_addr = 64'h100; bus.d_req = 1; tick(); bus.d_req = 0;
    chk("t1_grant", bus.mem_enable, 1);
    tick(); tick();
    reset_n = 0; tick(); reset_n = 1;
    chk("t1_rst_addr", bus.mem_addr, 0);
    chk("t1_rst_state", dut.r_state, IDLE);
    bus.mem_rdata = rdx; bus.mem_done = 1; tick(); bus.mem_done = 0;
    chk("t1_no_done", bus.d_done, 0);
    tick();

    // 2: single fetch, grant next edge, response 4 edges later
    bus.if_addr = 64'h1047; bus.if_req = 1; tick(); bus.if_req = 0;
    chk("t2_en", bus.mem_enable, 1);
    chk("t2_addr", bus.mem_addr, 64'h1040);
    tick();
    chk("t2_en_once", bus.mem_enable, 0);
    tick(); tick();
    bus.mem_rdata = rdx; bus.mem_done = 1; tick(); bus.mem_done = 0;
    chk("t2_if_done", bus.if_done, 1);
    chk("t2_if_data", bus.if_data, rdx);
    tick();
    chk("t2_done_once", bus.if_done, 0);

    // 3: simultaneous requests, data first, fetch right after
    bus.if_addr = 64'h9000; bus.d_addr = 64'h2000; bus.d_we = 0;
    bus.if_req = 1; bus.d_req = 1; tick(); bus.if_req = 0; bus.d_req = 0;
    chk("t3_d_first", bus.mem_addr, 64'h2000);
    serve(2, rd3a);
    chk("t3_d_done", bus.d_done, 1);
    chk("t3_d_data", bus.d_data, rd3a);
    chk("t3_gap", bus.mem_enable, 0);
    tick();
    chk("t3_if_en", bus.mem_enable, 1);
    chk("t3_if_addr", bus.mem_addr, 64'h9000);
    serve(2, rd3b);
    chk("t3_if_data", bus.if_data, rd3b);
    tick();

    // 4a: flush while a fetch is in flight
    bus.if_addr = 64'h3000; bus.if_req = 1; tick(); bus.if_req = 0;
    tick();
    bus.if_flush = 1; tick(); bus.if_flush = 0;
    bus.mem_rdata = rdx; bus.mem_done = 1; tick(); bus.mem_done = 0;
    chk("t4_suppressed", bus.if_done, 0);
    chk("t4_state", dut.r_state, IDLE);
    tick();
    chk("t4_still_quiet", bus.if_done, 0);
    // 4b: flush plus a new fetch on the same edge
    bus.if_addr = 64'h4000; bus.if_req = 1; tick(); bus.if_req = 0;
    tick();
    bus.if_flush = 1; bus.if_req = 1; bus.if_addr = 64'h5080; tick();
    bus.if_flush = 0; bus.if_req = 0;
    bus.mem_rdata = rdx; bus.mem_done = 1; tick(); bus.mem_done = 0;
    chk("t4b_old_dropped", bus.if_done, 0);
    tick();
    chk("t4b_new_en", bus.mem_enable, 1);
    chk("t4b_new_addr", bus.mem_addr, 64'h5080);
    serve(3, rd3b ^ rdx);
    chk("t4b_if_done", bus.if_done, 1);
    chk("t4b_if_data", bus.if_data, rd3b ^ rdx);
    tick();

    // 5: starvation, data re-requests on every completion
    m_log.delete();
    bus.if_addr = 64'h6000; bus.d_addr = 64'h7000;
    bus.if_req = 1; bus.d_req = 1; tick(); bus.if_req = 0; bus.d_req = 0;
    for (int i = 0; i < LIM; i++) begin
      serve(2, rd5 ^ LINE_W'(i));
      bus.d_addr = 64'h7000 + 64'(64 * (i + 1));
      bus.d_req = 1; tick(); bus.d_req = 0;
    end
    chk("t5_if_forced", bus.mem_addr, 64'h6000);
    chk("t5_starve_clr", dut.r_starve_cnt, 0);
    serve(2, rdx);
    chk("t5_if_data", bus.if_data, rdx);
    serve(2, rd5);
    chk("t5_log_len", m_log.size(), 6);
    for (int i = 0; i < 6; i++) chk("t5_order", m_log[i], (i == 4) ? 1 : 2);
    tick();

    // 6: masked line write
    bus.d_we = 1; bus.d_addr = 64'h803F; bus.d_wdata = pat; bus.d_wmask = 64'h00FF;
    bus.d_req = 1; tick(); bus.d_req = 0; bus.d_we = 0; bus.d_wdata = '0; bus.d_wmask = '0;
    chk("t6_we", bus.mem_we, 1);
    chk("t6_addr", bus.mem_addr, 64'h8000);
    tick(); tick();
    chk("t6_wmask_held", bus.mem_wmask, 64'h00FF);
    chk("t6_wdata_held", bus.mem_wdata, pat);
    bus.mem_rdata = rdx; bus.mem_done = 1; tick(); bus.mem_done = 0;
    chk("t6_d_done", bus.d_done, 1);
    chk("t6_d_data_kept", bus.d_data, rd5);
    tick();
    chk("t6_done_once", bus.d_done, 0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
